// File: rtl/lb_pkg.sv
// Shared definitions for the local-bus initiator.
// Bus width, burst address step, timeout fill word and FSM states.
package lb_pkg;

    localparam int LB_DW = 32;

    localparam logic [LB_DW-1:0] LB_ADDR_INC     = 32'd4;
    localparam logic [LB_DW-1:0] LB_TIMEOUT_DATA = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_FIN
    } lb_state_e;

endpackage

// File: rtl/lb_timeout_cnt.sv
// Loadable down-counter guarding one outstanding read.
// Loaded with LOAD-1, so expired rises after LOAD enabled cycles.
module lb_timeout_cnt #(
    parameter int unsigned LOAD = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (LOAD > 1) ? $clog2(LOAD) : 1;

    logic [W-1:0] cnt;

    // Reload on each read issue, count down while waiting, stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LOAD - 1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/lb_initiator.sv
// Local-bus initiator: burst commands to single-cycle lb_wr/lb_rd strobes.
// Reads are collected one at a time, with a timeout fill on silence.
module lb_initiator
    import lb_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYC  = 255,
    parameter logic [LB_DW-1:0]  TIMEOUT_DATA = LB_TIMEOUT_DATA,
    parameter logic [LB_DW-1:0]  ADDR_INC     = LB_ADDR_INC
) (
    input  logic             clk_lb,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [LB_DW-1:0] cmd_addr,
    input  logic [7:0]       cmd_len,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [LB_DW-1:0] wd_data,
    output logic             rsp_valid,
    output logic [LB_DW-1:0] rsp_data,
    output logic             rsp_err,
    output logic             done,
    output logic             busy,
    output logic             lb_wr,
    output logic             lb_rd,
    output logic [LB_DW-1:0] lb_addr,
    output logic [LB_DW-1:0] lb_wr_d,
    input  logic [LB_DW-1:0] lb_rd_d,
    input  logic             lb_rd_rdy
);

    lb_state_e        state;
    logic [LB_DW-1:0] addr;
    logic [8:0]       remain;
    logic             last;
    logic             tmo_expired;

    assign last     = (remain == 9'd1);
    assign wd_ready = (state == ST_WR_DATA);

    lb_timeout_cnt #(
        .LOAD (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk_lb),
        .rst_n   (reset_n),
        .load    (state == ST_RD_ISSUE),
        .en      (state == ST_RD_WAIT),
        .expired (tmo_expired)
    );

    // Burst sequencer; every bus and response output is registered here.
    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remain    <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lb_wr     <= 1'b0;
            lb_rd     <= 1'b0;
            lb_addr   <= '0;
            lb_wr_d   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            lb_wr     <= 1'b0;
            lb_rd     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        addr      <= cmd_addr;
                        remain    <= (cmd_len == 8'd0) ? 9'd1
                                                       : {1'b0, cmd_len};
                        state     <= cmd_wr ? ST_WR_DATA : ST_RD_ISSUE;
                    end
                end
                ST_WR_DATA: begin
                    if (wd_valid) begin
                        lb_wr   <= 1'b1;
                        lb_addr <= addr;
                        lb_wr_d <= wd_data;
                        addr    <= addr + ADDR_INC;
                        remain  <= remain - 9'd1;
                        if (last) state <= ST_FIN;
                    end
                end
                ST_RD_ISSUE: begin
                    lb_rd   <= 1'b1;
                    lb_addr <= addr;
                    state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // A response arriving on the expiry cycle still wins.
                    if (lb_rd_rdy || tmo_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= lb_rd_rdy ? lb_rd_d : TIMEOUT_DATA;
                        rsp_err   <= !lb_rd_rdy;
                        addr      <= addr + ADDR_INC;
                        remain    <= remain - 9'd1;
                        state     <= last ? ST_FIN : ST_RD_ISSUE;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lb_initiator.sv
// Directed bench for lb_initiator with a one-cycle-latency responder.
// Bus activity is logged on the falling edge and checked after each burst.
module tb_lb_initiator;

    logic        clk_lb = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        done;
    logic        busy;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy;

    int n_vec = 0;
    int n_mis = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] ra_q[$];
    logic [31:0] rs_q[$];
    logic [31:0] re_q[$];
    logic [31:0] rd_q[$];
    int          n_done = 0;
    int          n_both = 0;
    logic        resp_en = 1'b0;

    lb_initiator #(
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_lb    (clk_lb),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .done      (done),
        .busy      (busy),
        .lb_wr     (lb_wr),
        .lb_rd     (lb_rd),
        .lb_addr   (lb_addr),
        .lb_wr_d   (lb_wr_d),
        .lb_rd_d   (lb_rd_d),
        .lb_rd_rdy (lb_rd_rdy)
    );

    always #5 clk_lb = ~clk_lb;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Log bus strobes, responses and done pulses.
    always @(negedge clk_lb) begin
        if (lb_wr) begin
            wa_q.push_back(lb_addr);
            wd_q.push_back(lb_wr_d);
        end
        if (lb_rd) ra_q.push_back(lb_addr);
        if (rsp_valid) begin
            rs_q.push_back(rsp_data);
            re_q.push_back(32'(rsp_err));
        end
        if (done) n_done++;
        if (lb_wr && lb_rd) n_both++;
    end

    // Responder: answer each lb_rd one cycle later from rd_q.
    always begin
        @(posedge clk_lb);
        #1;
        lb_rd_rdy = 1'b0;
        if (lb_rd && resp_en) begin
            @(posedge clk_lb);
            #1;
            if (rd_q.size() > 0) lb_rd_d = rd_q.pop_front();
            else lb_rd_d = 32'hBAD0_BAD0;
            lb_rd_rdy = 1'b1;
        end
    end

    task automatic clr();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        rs_q.delete();
        re_q.delete();
        n_done = 0;
    endtask

    task automatic tick();
        @(posedge clk_lb);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a,
                            input logic [7:0] l);
        int n = 0;
        cmd_wr    = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (n_done == 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        chk(tag, 32'(n_done), 32'd1);
    endtask

    logic [31:0] exp_a[4];
    logic [31:0] gap_pat[6];

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        lb_rd_d   = '0;
        lb_rd_rdy = 1'b0;
        #17;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lb_addr", lb_addr, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_wd_ready", 32'(wd_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single write
        clr();
        send_cmd(1'b1, 32'h4, 8'd1);
        chk("sw_busy", 32'(busy), 32'd1);
        chk("sw_wd_ready", 32'(wd_ready), 32'd1);
        wd_valid = 1'b1;
        wd_data  = 32'hA5A5_0001;
        tick();
        wd_valid = 1'b0;
        chk("sw_lb_wr", 32'(lb_wr), 32'd1);
        chk("sw_lb_addr", lb_addr, 32'h4);
        chk("sw_lb_wr_d", lb_wr_d, 32'hA5A5_0001);
        tick();
        chk("sw_wr_pulse", 32'(lb_wr), 32'd0);
        chk("sw_done", 32'(done), 32'd1);
        chk("sw_busy_off", 32'(busy), 32'd0);
        chk("sw_ready_late", 32'(cmd_ready), 32'd0);
        tick();
        chk("sw_done_pulse", 32'(done), 32'd0);
        chk("sw_ready_back", 32'(cmd_ready), 32'd1);
        chk("sw_wr_count", 32'(wa_q.size()), 32'd1);

        // Read burst of three
        clr();
        resp_en = 1'b1;
        rd_q.push_back(32'h1234_5678);
        rd_q.push_back(32'h0000_0011);
        rd_q.push_back(32'h0000_0022);
        send_cmd(1'b0, 32'h0, 8'd3);
        tick();
        chk("rb_first_rd", 32'(lb_rd), 32'd1);
        wait_done("rb_done");
        chk("rb_rd_count", 32'(ra_q.size()), 32'd3);
        chk("rb_rsp_count", 32'(rs_q.size()), 32'd3);
        if (ra_q.size() == 3 && rs_q.size() == 3) begin
            chk("rb_addr0", ra_q[0], 32'h0);
            chk("rb_addr1", ra_q[1], 32'h4);
            chk("rb_addr2", ra_q[2], 32'h8);
            chk("rb_data0", rs_q[0], 32'h1234_5678);
            chk("rb_data1", rs_q[1], 32'h11);
            chk("rb_data2", rs_q[2], 32'h22);
            chk("rb_err", re_q[0] | re_q[1] | re_q[2], 32'd0);
        end

        // Read timeout with a late response injected between reads
        clr();
        resp_en = 1'b0;
        send_cmd(1'b0, 32'h100, 8'd2);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin
                tick();
                n++;
            end
        end
        chk("to_first_rsp", 32'(rsp_valid), 32'd1);
        #1;
        lb_rd_d   = 32'h5555_5555;
        lb_rd_rdy = 1'b1;
        wait_done("to_done");
        chk("to_rd_count", 32'(ra_q.size()), 32'd2);
        chk("to_rsp_count", 32'(rs_q.size()), 32'd2);
        if (rs_q.size() == 2 && ra_q.size() == 2) begin
            chk("to_addr1", ra_q[1], 32'h104);
            chk("to_data0", rs_q[0], 32'hDEAD_DEAD);
            chk("to_data1", rs_q[1], 32'hDEAD_DEAD);
            chk("to_err0", re_q[0], 32'd1);
            chk("to_err1", re_q[1], 32'd1);
        end

        // Write burst with gaps, wrapping through zero
        clr();
        gap_pat = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd0, 32'd1};
        exp_a   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        send_cmd(1'b1, 32'hFFFF_FFF8, 8'd4);
        begin
            int k = 0;
            for (int i = 0; i < 6; i++) begin
                wd_valid = gap_pat[i][0];
                wd_data  = 32'hB000_0000 + 32'(k);
                if (gap_pat[i][0]) k++;
                tick();
            end
        end
        wd_valid = 1'b0;
        wait_done("gw_done");
        chk("gw_wr_count", 32'(wa_q.size()), 32'd4);
        if (wa_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("gw_addr", wa_q[i], exp_a[i]);
                chk("gw_data", wd_q[i], 32'hB000_0000 + 32'(i));
            end
        end

        // len=0 read behaves as a single word
        clr();
        resp_en = 1'b1;
        rd_q.push_back(32'hCAFE_0000);
        send_cmd(1'b0, 32'h40, 8'd0);
        wait_done("l0_done");
        chk("l0_rd_count", 32'(ra_q.size()), 32'd1);
        chk("l0_rsp_count", 32'(rs_q.size()), 32'd1);
        if (rs_q.size() == 1) chk("l0_data", rs_q[0], 32'hCAFE_0000);

        // Asynchronous reset mid-burst
        clr();
        rd_q.push_back(32'h7777_0001);
        rd_q.push_back(32'h7777_0002);
        send_cmd(1'b0, 32'h200, 8'd4);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin
                tick();
                n++;
            end
        end
        chk("ar_rsp_seen", 32'(rsp_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_rsp_data", rsp_data, 32'd0);
        chk("ar_lb_addr", lb_addr, 32'd0);
        chk("ar_lb_wr_d", lb_wr_d, 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        rd_q.delete();
        clr();
        tick();
        tick();
        @(negedge clk_lb);
        reset_n = 1'b1;
        tick();
        tick();
        chk("ar_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("ar_no_rd", 32'(ra_q.size()), 32'd0);
        chk("ar_no_done", 32'(n_done), 32'd0);
        send_cmd(1'b1, 32'h300, 8'd2);
        wd_valid = 1'b1;
        wd_data  = 32'hC000_0000;
        tick();
        wd_data  = 32'hC000_0001;
        tick();
        wd_valid = 1'b0;
        wait_done("ar_new_done");
        chk("ar_wr_count", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("ar_wr_addr1", wa_q[1], 32'h304);
            chk("ar_wr_data1", wd_q[1], 32'hC000_0001);
        end

        chk("never_wr_and_rd", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
